// File: rtl/cisc_bus_pkg.sv
// Shared definitions for the bus cycle sequencer: T-state codes, sequencer states and the
// dtr_ direction encoding.
package cisc_bus_pkg;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  localparam logic [2:0] T5 = 3'd5;
  localparam logic [2:0] T6 = 3'd6;
  localparam logic [2:0] T7 = 3'd7;

  typedef enum logic {StIdle, StCycle} bus_state_e;

  localparam logic DIR_WR = 1'b1;
  localparam logic DIR_RD = 1'b0;

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state counter for T5: counts cycles with ready low and flags the cycle on which the
// MAX_WAIT-th wait would be reached so the sequencer can force-advance.
module bus_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_t5,
  input  logic ready,
  output logic expired
);

  localparam int unsigned CntW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  logic [CntW-1:0] count_q;

  assign expired = in_t5 && !ready && (count_q == CntW'(MAX_WAIT - 1));

  // Held at zero outside T5, so every entry to T5 starts a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (!in_t5) begin
      count_q <= '0;
    end else if (!ready && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/bus_cycle_sequencer.sv
// Sequences single-word read/write requests through the eight-T-state bus cycle and owns the
// AD bus. Optional wait-state timeout is enabled by defining BUS_WAIT_TIMEOUT_EN.
module bus_cycle_sequencer
  import cisc_bus_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        ack,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        err,
  input  logic        ready,
  output logic [2:0]  t_state,
  output logic        busint,
  output logic        dtr_,
  output logic [15:0] ad_out,
  output logic        ad_oe,
  input  logic [15:0] ad_in
);

  bus_state_e  state_q;
  logic [15:0] wdata_q;
  logic        wr_q;
  logic        timed_out_q;
  logic        err_q;
  logic        accept;
  logic        in_t5;
  logic        expired;

  assign in_t5  = (state_q == StCycle) && (t_state == T5);
  assign accept = req && ((state_q == StIdle) || (t_state == T7));

`ifdef BUS_WAIT_TIMEOUT_EN
  bus_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_t5   (in_t5),
    .ready   (ready),
    .expired (expired)
  );

  assign err = err_q;
`else
  logic unused_cfg;

  assign expired    = 1'b0;
  assign err        = 1'b0;
  assign unused_cfg = ^{MAX_WAIT, err_q, timed_out_q};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      t_state     <= T0;
      busint      <= 1'b0;
      busy        <= 1'b0;
      dtr_        <= DIR_RD;
      ack         <= 1'b0;
      err_q       <= 1'b0;
      rdata       <= 16'h0000;
      ad_out      <= 16'h0000;
      ad_oe       <= 1'b0;
      wdata_q     <= 16'h0000;
      wr_q        <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      ack   <= 1'b0;
      err_q <= 1'b0;
      if (accept) begin
        // Covers both a fresh start from IDLE and a back-to-back start out of T7.
        state_q     <= StCycle;
        t_state     <= T0;
        busint      <= 1'b1;
        busy        <= 1'b1;
        dtr_        <= req_wr ? DIR_WR : DIR_RD;
        wdata_q     <= req_wdata;
        wr_q        <= req_wr;
        ad_out      <= req_addr;
        ad_oe       <= 1'b1;
        timed_out_q <= 1'b0;
      end else if (state_q == StCycle) begin
        unique case (t_state)
          T1: begin
            t_state <= T2;
            ad_oe   <= wr_q;
            ad_out  <= wr_q ? wdata_q : 16'h0000;
          end
          T5: begin
            if (ready) begin
              t_state <= T6;
              if (!wr_q) begin
                rdata <= ad_in;
              end
            end else if (expired) begin
              t_state     <= T6;
              timed_out_q <= 1'b1;
            end
          end
          T6: begin
            t_state <= T7;
            ack     <= 1'b1;
            err_q   <= timed_out_q;
          end
          T7: begin
            state_q <= StIdle;
            t_state <= T0;
            busint  <= 1'b0;
            busy    <= 1'b0;
            dtr_    <= DIR_RD;
            ad_out  <= 16'h0000;
            ad_oe   <= 1'b0;
          end
          default: t_state <= t_state + 3'd1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Directed self-checking bench for bus_cycle_sequencer; timeout scenario runs only when
// BUS_WAIT_TIMEOUT_EN is defined.
module tb_bus_cycle_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        ack;
  logic [15:0] rdata;
  logic        busy;
  logic        err;
  logic        ready;
  logic [2:0]  t_state;
  logic        busint;
  logic        dtr_;
  logic [15:0] ad_out;
  logic        ad_oe;
  logic [15:0] ad_in;

  int n_cmp = 0;
  int n_err = 0;

  // Packed view of the control outputs: {t_state, busint, dtr_, ad_oe, ack, busy, err}
  logic [8:0] obs;
  assign obs = {t_state, busint, dtr_, ad_oe, ack, busy, err};

  always #5 clk = ~clk;

`ifdef BUS_WAIT_TIMEOUT_EN
  localparam int unsigned TbMaxWait = 4;
`else
  localparam int unsigned TbMaxWait = 15;
`endif

  bus_cycle_sequencer #(
    .MAX_WAIT (TbMaxWait)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .rdata     (rdata),
    .busy      (busy),
    .err       (err),
    .ready     (ready),
    .t_state   (t_state),
    .busint    (busint),
    .dtr_      (dtr_),
    .ad_out    (ad_out),
    .ad_oe     (ad_oe),
    .ad_in     (ad_in)
  );

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if (obs !== 9'b000_0_0_0_0_0_0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want %b", obs, 9'b0);
    end
    n_cmp++;
    if ({rdata, ad_out} !== 32'h0) begin
      n_err++;
      $display("FAIL reset_data: got rdata=%h ad_out=%h want 0/0", rdata, ad_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== 9'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got %b want %b", obs, 9'b0);
    end
  endtask

  task automatic test_read();
    logic [8:0]  exp;
    logic [15:0] exp_ad;
    req = 1'b1; req_wr = 1'b0; req_addr = 16'h1234; req_wdata = 16'h5555;
    ready = 1'b1; ad_in = 16'hDEAD;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp    = {3'(i), 1'b1, 1'b0, (i < 2), (i == 7), 1'b1, 1'b0};
      exp_ad = (i < 2) ? 16'h1234 : 16'h0000;
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL read_ctrl[%0d]: got %b want %b", i, obs, exp);
      end
      n_cmp++;
      if (ad_out !== exp_ad) begin
        n_err++;
        $display("FAIL read_ad[%0d]: got %h want %h", i, ad_out, exp_ad);
      end
      if (i == 5) begin
        n_cmp++;
        if (rdata !== 16'h0000) begin
          n_err++;
          $display("FAIL read_early_rdata: got %h want 0000", rdata);
        end
      end
      if (i == 7) begin
        n_cmp++;
        if (rdata !== 16'hBEEF) begin
          n_err++;
          $display("FAIL read_rdata: got %h want beef", rdata);
        end
      end
      req   = 1'b0;
      ad_in = (i == 5) ? 16'hBEEF : 16'hDEAD;
    end
    @(negedge clk);
    n_cmp++;
    if (obs !== 9'b0) begin
      n_err++;
      $display("FAIL read_return_idle: got %b want %b", obs, 9'b0);
    end
  endtask

  task automatic test_write();
    logic [8:0]  exp;
    logic [15:0] exp_ad;
    req = 1'b1; req_wr = 1'b1; req_addr = 16'h00F0; req_wdata = 16'hA5A5;
    ad_in = 16'h7777;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp    = {3'(i), 1'b1, 1'b1, 1'b1, (i == 7), 1'b1, 1'b0};
      exp_ad = (i < 2) ? 16'h00F0 : 16'hA5A5;
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL write_ctrl[%0d]: got %b want %b", i, obs, exp);
      end
      n_cmp++;
      if (ad_out !== exp_ad) begin
        n_err++;
        $display("FAIL write_ad[%0d]: got %h want %h", i, ad_out, exp_ad);
      end
      req = 1'b0;
    end
    n_cmp++;
    if (rdata !== 16'hBEEF) begin
      n_err++;
      $display("FAIL write_keeps_rdata: got %h want beef", rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_wait_states();
    logic [2:0] seq [11] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd5, 3'd5, 3'd6, 3'd7};
    logic [8:0] exp;
    req = 1'b1; req_wr = 1'b0; req_addr = 16'h2222; ready = 1'b1; ad_in = 16'h0BAD;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      exp = {seq[i], 1'b1, 1'b0, (i < 2), (i == 10), 1'b1, 1'b0};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL wait_ctrl[%0d]: got %b want %b", i, obs, exp);
      end
      if (i == 8 || i == 10) begin
        n_cmp++;
        if (rdata !== ((i == 8) ? 16'hBEEF : 16'h1357)) begin
          n_err++;
          $display("FAIL wait_rdata[%0d]: got %h want %h", i, rdata,
                   (i == 8) ? 16'hBEEF : 16'h1357);
        end
      end
      req   = 1'b0;
      ready = !(i >= 4 && i <= 7);
      ad_in = (i == 8) ? 16'h1357 : 16'h0BAD;
    end
    ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [8:0]  exp;
    logic [15:0] exp_ad;
    int          ack_cnt = 0;
    int          first_ack = -1;
    int          last_ack = -1;
    req = 1'b1; req_wr = 1'b1; req_addr = 16'h0100; req_wdata = 16'h1111;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp = {3'(i % 8), 1'b1, 1'b1, 1'b1, ((i % 8) == 7), 1'b1, 1'b0};
      if (i < 8) exp_ad = ((i % 8) < 2) ? 16'h0100 : 16'h1111;
      else       exp_ad = ((i % 8) < 2) ? 16'h0200 : 16'h2222;
      n_cmp++;
      if (obs !== exp || ad_out !== exp_ad) begin
        n_err++;
        $display("FAIL b2b[%0d]: got %b/%h want %b/%h", i, obs, ad_out, exp, exp_ad);
      end
      if (ack) begin
        ack_cnt++;
        if (first_ack < 0) first_ack = i;
        last_ack = i;
      end
      if (i == 7) begin
        req_addr = 16'h0200; req_wdata = 16'h2222;
      end
      if (i == 8) req = 1'b0;
    end
    n_cmp++;
    if (ack_cnt !== 2 || (last_ack - first_ack) !== 8) begin
      n_err++;
      $display("FAIL b2b_acks: got count=%0d spacing=%0d want 2/8", ack_cnt, last_ack - first_ack);
    end
    @(negedge clk);
    n_cmp++;
    if (obs !== 9'b0) begin
      n_err++;
      $display("FAIL b2b_idle: got %b want %b", obs, 9'b0);
    end
  endtask

  task automatic test_reset_mid_cycle();
    int acks = 0;
    req = 1'b1; req_wr = 1'b1; req_addr = 16'h0300; req_wdata = 16'hCAFE;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req = 1'b0;
    end
    n_cmp++;
    if (t_state !== 3'd3) begin
      n_err++;
      $display("FAIL rst_mid_pre: got t_state=%0d want 3", t_state);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 9'b0 || {rdata, ad_out} !== 32'h0) begin
      n_err++;
      $display("FAIL rst_mid_async: got %b rdata=%h ad_out=%h want all 0", obs, rdata, ad_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack || busy || busint || t_state != 3'd0) acks++;
    end
    n_cmp++;
    if (acks !== 0) begin
      n_err++;
      $display("FAIL rst_mid_stays_idle: got %0d active cycles want 0", acks);
    end
  endtask

`ifdef BUS_WAIT_TIMEOUT_EN
  task automatic test_timeout();
    logic [2:0] seq [11] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd5, 3'd5, 3'd6, 3'd7};
    logic [8:0] exp;
    req = 1'b1; req_wr = 1'b0; req_addr = 16'h4444; ready = 1'b1; ad_in = 16'hFFFF;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      exp = {seq[i], 1'b1, 1'b0, (i < 2), (i == 10), 1'b1, (i == 10)};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL timeout_ctrl[%0d]: got %b want %b", i, obs, exp);
      end
      req   = 1'b0;
      ready = (i < 4);
    end
    n_cmp++;
    if (rdata !== 16'h0000) begin
      n_err++;
      $display("FAIL timeout_rdata: got %h want 0000", rdata);
    end
    ready = 1'b1;
    @(negedge clk);
  endtask
`endif

  initial begin
    rst_n = 1'b0; req = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    ready = 1'b1; ad_in = '0;
    test_reset();
    test_read();
    test_write();
    test_wait_states();
    test_back_to_back();
    test_reset_mid_cycle();
`ifdef BUS_WAIT_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
